elev_req_scheduler: RTL and testbench

//  Parametrised hall/cab request scheduler for an N-floor elevator controller.

---
 rtl/elev_req_scheduler_pkg.sv | 27 ++
 rtl/elev_req_scheduler_floor_mask.sv | 24 ++
 rtl/elev_req_scheduler.sv | 165 ++++++++++++++++
 tb/tb_elev_req_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/elev_req_scheduler_pkg.sv
// Shared direction encoding and helpers for the elevator request scheduler.
package elev_req_scheduler_pkg;

  // Direction codes share their encoding with ud_mode in the motion controller.
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    DirIdle = DIR_IDLE,
    DirUp   = DIR_UP,
    DirDown = DIR_DOWN
  } dir_e;

  // Widest vector popcount accepts; callers zero-extend into it.
  localparam int unsigned POP_MAX_W = 96;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt += 32'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/elev_req_scheduler_floor_mask.sv
// Position decoder: masks of floors strictly above/below a one-hot position,
// plus a flag telling whether the position really is one-hot.
module elev_req_scheduler_floor_mask #(
  parameter int unsigned N_FLOORS = 4
) (
  input  logic [N_FLOORS-1:0] i_position,
  output logic [N_FLOORS-1:0] o_above_mask,
  output logic [N_FLOORS-1:0] o_below_mask,
  output logic                o_onehot_ok
);

  localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);

  logic [N_FLOORS-1:0] w_pos_m1;

  // For a one-hot p, p-1 sets exactly the bits below p; masks are don't-care otherwise.
  always_comb begin
    w_pos_m1     = i_position - ONE;
    o_below_mask = w_pos_m1 & ~i_position;
    o_above_mask = ~(w_pos_m1 | i_position);
    o_onehot_ok  = (i_position != '0) && ((i_position & w_pos_m1) == '0);
  end

endmodule

// File: rtl/elev_req_scheduler.sv
// Hall/cab request scheduler: latches requests, cancels them on arrival and
// runs the IDLE/UP/DOWN direction FSM that drives the motion controller.
module elev_req_scheduler
  import elev_req_scheduler_pkg::*;
#(
  parameter int unsigned N_FLOORS = 4,
  parameter int unsigned CNT_W    = $clog2(3 * N_FLOORS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] i_up_req,
  input  logic [N_FLOORS-1:0] i_down_req,
  input  logic [N_FLOORS-1:0] i_cab_req,
  input  logic [N_FLOORS-1:0] i_position,
  input  logic                i_at_floor,
  output logic [N_FLOORS-1:0] o_up_pend,
  output logic [N_FLOORS-1:0] o_down_pend,
  output logic [N_FLOORS-1:0] o_cab_pend,
  output logic [N_FLOORS-1:0] o_all_pend,
  output logic                o_up_need,
  output logic                o_down_need,
  output logic                o_stop_here,
  output logic [CNT_W-1:0]    o_pending_cnt,
  output logic                o_pos_err
);

  // No hall-up key on the top floor and no hall-down key on the ground floor.
  localparam logic [N_FLOORS-1:0] UP_OK   = {1'b0, {(N_FLOORS - 1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DOWN_OK = {{(N_FLOORS - 1){1'b1}}, 1'b0};

  logic [N_FLOORS-1:0] r_up_pend;
  logic [N_FLOORS-1:0] r_down_pend;
  logic [N_FLOORS-1:0] r_cab_pend;
  logic [N_FLOORS-1:0] r_all_pend;
  dir_e                r_state;
  logic                r_up_need;
  logic                r_down_need;
  logic                r_stop_here;
  logic [CNT_W-1:0]    r_pending_cnt;
  logic                r_pos_err;

  logic [N_FLOORS-1:0] w_above_mask;
  logic [N_FLOORS-1:0] w_below_mask;
  logic                w_pos_ok;
  logic [N_FLOORS-1:0] w_all_q;
  logic                w_any_above;
  logic                w_any_below;
  logic [N_FLOORS-1:0] w_up_clr;
  logic [N_FLOORS-1:0] w_down_clr;
  logic [N_FLOORS-1:0] w_cab_clr;
  logic [N_FLOORS-1:0] w_up_d;
  logic [N_FLOORS-1:0] w_down_d;
  logic [N_FLOORS-1:0] w_cab_d;
  dir_e                w_state_d;
  logic [N_FLOORS-1:0] w_stop_vec;
  logic                w_stop_here;

  elev_req_scheduler_floor_mask #(
    .N_FLOORS(N_FLOORS)
  ) u_floor_mask (
    .i_position  (i_position),
    .o_above_mask(w_above_mask),
    .o_below_mask(w_below_mask),
    .o_onehot_ok (w_pos_ok)
  );

  // Outstanding work relative to the car, from the currently latched requests.
  always_comb begin
    w_all_q     = r_up_pend | r_down_pend | r_cab_pend;
    w_any_above = |(w_all_q & w_above_mask);
    w_any_below = |(w_all_q & w_below_mask);
  end

  // Arrival clears: only with doors open at a trustworthy position.
  always_comb begin
    w_up_clr   = '0;
    w_down_clr = '0;
    w_cab_clr  = '0;
    if (i_at_floor && w_pos_ok) begin
      w_cab_clr = i_position;
      if (r_state != DirDown) w_up_clr = i_position;
      if (r_state != DirUp) w_down_clr = i_position;
      // Direction exhausted: the car turns here, so the opposite hall call is served too.
      if ((r_state == DirUp) && !w_any_above) w_down_clr = i_position;
      if ((r_state == DirDown) && !w_any_below) w_up_clr = i_position;
    end
  end

  // Next pending vectors; a clear beats a set of the same bit.
  always_comb begin
    w_up_d   = (r_up_pend | (i_up_req & UP_OK)) & ~w_up_clr;
    w_down_d = (r_down_pend | (i_down_req & DOWN_OK)) & ~w_down_clr;
    w_cab_d  = (r_cab_pend | i_cab_req) & ~w_cab_clr;
  end

  // Direction FSM next state; frozen while moving and on a bad position.
  always_comb begin
    w_state_d = r_state;
    if (w_pos_ok && (i_at_floor || (r_state == DirIdle))) begin
      case (r_state)
        DirDown: begin
          if (w_any_below) w_state_d = DirDown;
          else if (w_any_above) w_state_d = DirUp;
          else w_state_d = DirIdle;
        end
        default: begin
          // IDLE and UP share priority: upward work wins a tie.
          if (w_any_above) w_state_d = DirUp;
          else if (w_any_below) w_state_d = DirDown;
          else w_state_d = DirIdle;
        end
      endcase
    end
  end

  // Stop decision: cab calls always, hall calls matching the travel direction.
  always_comb begin
    case (r_state)
      DirUp:   w_stop_vec = r_cab_pend | r_up_pend;
      DirDown: w_stop_vec = r_cab_pend | r_down_pend;
      default: w_stop_vec = r_cab_pend | r_up_pend | r_down_pend;
    endcase
    if ((r_state == DirUp) && !w_any_above) w_stop_vec = w_stop_vec | r_down_pend;
    if ((r_state == DirDown) && !w_any_below) w_stop_vec = w_stop_vec | r_up_pend;
    w_stop_here = w_pos_ok & |(i_position & w_stop_vec);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up_pend     <= '0;
      r_down_pend   <= '0;
      r_cab_pend    <= '0;
      r_all_pend    <= '0;
      r_state       <= DirIdle;
      r_up_need     <= 1'b0;
      r_down_need   <= 1'b0;
      r_stop_here   <= 1'b0;
      r_pending_cnt <= '0;
      r_pos_err     <= 1'b0;
    end else begin
      r_up_pend     <= w_up_d;
      r_down_pend   <= w_down_d;
      r_cab_pend    <= w_cab_d;
      r_all_pend    <= w_up_d | w_down_d | w_cab_d;
      r_state       <= w_state_d;
      r_up_need     <= (w_state_d == DirUp);
      r_down_need   <= (w_state_d == DirDown);
      r_stop_here   <= w_stop_here;
      r_pending_cnt <= CNT_W'(popcount(POP_MAX_W'({w_up_d, w_down_d, w_cab_d})));
      r_pos_err     <= ~w_pos_ok;
    end
  end

  assign o_up_pend     = r_up_pend;
  assign o_down_pend   = r_down_pend;
  assign o_cab_pend    = r_cab_pend;
  assign o_all_pend    = r_all_pend;
  assign o_up_need     = r_up_need;
  assign o_down_need   = r_down_need;
  assign o_stop_here   = r_stop_here;
  assign o_pending_cnt = r_pending_cnt;
  assign o_pos_err     = r_pos_err;

endmodule

// File: tb/tb_elev_req_scheduler.sv
// Self-checking bench for elev_req_scheduler with N_FLOORS=4.
module tb_elev_req_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [3:0] up;
    logic [3:0] down;
    logic [3:0] cab;
    logic [3:0] allp;
    logic       un;
    logic       dn;
    logic       sh;
    logic [3:0] cnt;
    logic       pe;
  } out_t;

  typedef struct packed {
    logic [3:0] ur;
    logic [3:0] dr;
    logic [3:0] cr;
    logic [3:0] pos;
    logic       at;
    out_t       exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  up_req, down_req, cab_req, position;
  logic          at_floor;
  logic [N-1:0]  up_pend, down_pend, cab_pend, all_pend;
  logic          up_need, down_need, stop_here, pos_err;
  logic [CW-1:0] pending_cnt;

  int   errors = 0;
  int   checks = 0;
  out_t exp_q[$];
  int   id_q[$];
  vec_t tbl[$];
  out_t zero;

  elev_req_scheduler #(
    .N_FLOORS(N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_up_req     (up_req),
    .i_down_req   (down_req),
    .i_cab_req    (cab_req),
    .i_position   (position),
    .i_at_floor   (at_floor),
    .o_up_pend    (up_pend),
    .o_down_pend  (down_pend),
    .o_cab_pend   (cab_pend),
    .o_all_pend   (all_pend),
    .o_up_need    (up_need),
    .o_down_need  (down_need),
    .o_stop_here  (stop_here),
    .o_pending_cnt(pending_cnt),
    .o_pos_err    (pos_err)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [3:0] u, input logic [3:0] d, input logic [3:0] c,
                              input logic un, input logic dn, input logic sh,
                              input logic [3:0] cnt, input logic pe);
    out_t o;
    o.up = u; o.down = d; o.cab = c; o.allp = u | d | c;
    o.un = un; o.dn = dn; o.sh = sh; o.cnt = cnt; o.pe = pe;
    return o;
  endfunction

  function automatic vec_t v(input logic [3:0] ur, input logic [3:0] dr, input logic [3:0] cr,
                             input logic [3:0] pos, input logic at, input out_t e);
    vec_t r;
    r.ur = ur; r.dr = dr; r.cr = cr; r.pos = pos; r.at = at; r.exp = e;
    return r;
  endfunction

  task automatic compare(input int id, input out_t e);
    out_t a;
    a.up = up_pend; a.down = down_pend; a.cab = cab_pend; a.allp = all_pend;
    a.un = up_need; a.dn = down_need; a.sh = stop_here; a.cnt = pending_cnt; a.pe = pos_err;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL chk%0d: got up=%b down=%b cab=%b all=%b upn=%b dnn=%b stop=%b cnt=%0d perr=%b; want up=%b down=%b cab=%b all=%b upn=%b dnn=%b stop=%b cnt=%0d perr=%b",
               id, a.up, a.down, a.cab, a.allp, a.un, a.dn, a.sh, a.cnt, a.pe,
               e.up, e.down, e.cab, e.allp, e.un, e.dn, e.sh, e.cnt, e.pe);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input logic [3:0] ur, input logic [3:0] dr, input logic [3:0] cr,
                      input logic [3:0] pos, input logic at, input out_t e, input int id);
    out_t ex;
    int   ix;
    up_req = ur; down_req = dr; cab_req = cr; position = pos; at_floor = at;
    exp_q.push_back(e);
    id_q.push_back(id);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL chk%0d: scoreboard empty got 0 entries want 1", id);
    end else begin
      ex = exp_q.pop_front();
      ix = id_q.pop_front();
      compare(ix, ex);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached got no finish want finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    zero = mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst = 1'b1;
    up_req = '0; down_req = '0; cab_req = '0; position = 4'h1; at_floor = 1'b1;
    #3 compare(1, zero);
    #9 compare(2, zero);
    rst = 1'b0;

    // Cab call to the top floor from IDLE at ground, then arrival there.
    step(4'h0, 4'h0, 4'h8, 4'h1, 1'b1, mk(4'h0, 4'h0, 4'h8, 0, 0, 0, 4'd1, 0), 3);
    cab_req = 4'h0;
    n = 0;
    while (!up_need && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL chk4: up_need latency got %0d clks want 1", n);
    end
    compare(5, mk(4'h0, 4'h0, 4'h8, 1, 0, 0, 4'd1, 0));
    step(4'h0, 4'h0, 4'h0, 4'h2, 1'b0, mk(4'h0, 4'h0, 4'h8, 1, 0, 0, 4'd1, 0), 6);
    step(4'h0, 4'h0, 4'h0, 4'h8, 1'b0, mk(4'h0, 4'h0, 4'h8, 1, 0, 1, 4'd1, 0), 7);
    step(4'h0, 4'h0, 4'h0, 4'h8, 1'b1, mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 0), 8);
    step(4'h0, 4'h0, 4'h0, 4'h8, 1'b1, zero, 9);

    // Scripted run: up trip with a hall-down call, turnaround, same-floor presses,
    // UP/DOWN tie, tied-off keys, invalid positions.
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h1, 1, zero));
    tbl.push_back(v(4'h0, 4'h0, 4'h8, 4'h1, 1, mk(4'h0, 4'h0, 4'h8, 0, 0, 0, 4'd1, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h1, 1, mk(4'h0, 4'h0, 4'h8, 1, 0, 0, 4'd1, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h2, 0, mk(4'h0, 4'h0, 4'h8, 1, 0, 0, 4'd1, 0)));
    tbl.push_back(v(4'h0, 4'h5, 4'h0, 4'h2, 0, mk(4'h0, 4'h4, 4'h8, 1, 0, 0, 4'd2, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h4, 0, mk(4'h0, 4'h4, 4'h8, 1, 0, 0, 4'd2, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h8, 0, mk(4'h0, 4'h4, 4'h8, 1, 0, 1, 4'd2, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h8, 1, mk(4'h0, 4'h4, 4'h0, 0, 1, 1, 4'd1, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h8, 1, mk(4'h0, 4'h4, 4'h0, 0, 1, 0, 4'd1, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h4, 0, mk(4'h0, 4'h4, 4'h0, 0, 1, 1, 4'd1, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h4, 1, mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h4, 1, zero));
    tbl.push_back(v(4'h0, 4'h0, 4'h2, 4'h2, 1, zero));
    tbl.push_back(v(4'h2, 4'h2, 4'h2, 4'h2, 1, zero));
    tbl.push_back(v(4'h0, 4'h8, 4'h1, 4'h4, 1, mk(4'h0, 4'h8, 4'h1, 0, 0, 0, 4'd2, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h4, 1, mk(4'h0, 4'h8, 4'h1, 1, 0, 0, 4'd2, 0)));
    tbl.push_back(v(4'h8, 4'h1, 4'h0, 4'h4, 1, mk(4'h0, 4'h8, 4'h1, 1, 0, 0, 4'd2, 0)));
    tbl.push_back(v(4'h1, 4'h0, 4'h0, 4'h6, 1, mk(4'h1, 4'h8, 4'h1, 1, 0, 0, 4'd3, 1)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h3, 1, mk(4'h1, 4'h8, 4'h1, 1, 0, 0, 4'd3, 1)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h0, 0, mk(4'h1, 4'h8, 4'h1, 1, 0, 0, 4'd3, 1)));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h1, 1, mk(4'h0, 4'h8, 4'h0, 1, 0, 1, 4'd1, 0)));
    tbl.push_back(v(4'h0, 4'h0, 4'h2, 4'h1, 0, mk(4'h0, 4'h8, 4'h2, 1, 0, 0, 4'd2, 0)));
    foreach (tbl[i]) begin
      step(tbl[i].ur, tbl[i].dr, tbl[i].cr, tbl[i].pos, tbl[i].at, tbl[i].exp, 100 + i);
    end

    // Reset mid-operation (pending 1010, UP): outputs clear before any edge.
    #2 rst = 1'b1;
    #1 compare(10, zero);
    cab_req = 4'hF; up_req = 4'h7; position = 4'h1; at_floor = 1'b1;
    @(posedge clk);
    #1 compare(11, zero);
    rst = 1'b0;

    // Downward trip ending with the exhausted-direction hall-up served at ground.
    step(4'h1, 4'h0, 4'h0, 4'h4, 1'b1, mk(4'h1, 4'h0, 4'h0, 0, 0, 0, 4'd1, 0), 12);
    step(4'h0, 4'h0, 4'h0, 4'h4, 1'b1, mk(4'h1, 4'h0, 4'h0, 0, 1, 0, 4'd1, 0), 13);
    step(4'h0, 4'h0, 4'h0, 4'h1, 1'b0, mk(4'h1, 4'h0, 4'h0, 0, 1, 1, 4'd1, 0), 14);
    step(4'h0, 4'h0, 4'h0, 4'h1, 1'b1, mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 0), 15);
    step(4'h0, 4'h0, 4'h0, 4'h1, 1'b1, zero, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
